ra_stack: RTL and testbench
===========================

# ra_stack

Circular return-address stack for the 16-bit core's program counting system. It captures the live RA on every call (push) and returns the most recent saved RA on every return (pop). The popped value is presented on `RArestore`, with a one-cycle `restore` pulse, so the PC/RA unit can reload RA on nested returns. It sits beside the PC/RA unit and is driven by the control unit's call/return decode.

## Interface
Parameters:
- `DEPTH`, 8 — number of stack entries; power of two, ≥2
- `WIDTH`, 16 — address width, matches PC/RA

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `push`  in  1  store `RA` on top of stack this cycle
- `pop`  in  1  remove top entry this cycle
- `RA`  in  WIDTH  current RA from the PC/RA unit
- `clear_err`  in  1  synchronous clear of the sticky error flags
- `RArestore`  out  WIDTH  registered popped value
- `restore`  out  1  one-cycle pulse: `RArestore` is valid
- `count`  out  $clog2(DEPTH)+1  number of valid entries
- `full`  out  1  `count == DEPTH`
- `empty`  out  1  `count == 0`
- `overflow`  out  1  sticky: a push dropped the oldest entry
- `underflow`  out  1  sticky: a pop was issued while empty

## Operation
- State: entry array, top pointer `tp` (index of next free slot), `count`, output register, flags.
- Reset (async, `reset`=0): `tp`=0, `count`=0, `RArestore`=0, `restore`=0, `overflow`=0, `underflow`=0. Entry contents are not reset.
- Push only, not full: `mem[tp]`←`RA`; `tp`←`tp`+1 (mod DEPTH); `count`+1.
- Push only, full: same write and pointer advance, so the oldest entry is overwritten. `count` stays DEPTH; `overflow`←1.
- Pop only, not empty: `RArestore`←`mem[tp-1]`; `tp`←`tp`−1 (mod DEPTH); `count`−1; `restore`←1 next cycle.
- Pop only, empty: `RArestore` unchanged; `restore` stays 0; `underflow`←1; `tp`/`count` unchanged.
- Push and pop together, not empty: `RArestore`←old `mem[tp-1]` and `restore`←1. `RA` is then written to slot `tp-1`. `tp` and `count` are unchanged (replace top).
- Push and pop together, empty: behaves as push only, and `underflow`←1.
- `clear_err`: clears `overflow` and `underflow`. If it coincides with a new error event, the set wins.
- `RArestore` holds its last popped value until the next successful pop.

## Timing
- Pop latency is 1 cycle: pop sampled at edge N gives `restore`=1 and valid `RArestore` after edge N, for exactly one cycle.
- A push at edge N is poppable at edge N+1. Back-to-back push→pop returns the just-pushed value.
- `count`, `full`, `empty`, and the flags are registered and update at the same edge as the operation.
- Continuous pops drain one entry per cycle, with `restore` high every cycle until empty.
- Reset mid-pop: `restore` drops immediately (async) and the stack is empty.

## Structure
- Shared package `pcs_pkg`: `WIDTH`=16 constant, `RA_STACK_DEPTH` default, pointer width derived via `$clog2`.
- Sub-module `ra_stack_mem`: DEPTH×WIDTH register file with one write port, one async read port, no reset. All pointer, count, and flag logic lives in `ra_stack`.

## Test plan
- Reset with `reset`=0 mid-operation → all outputs 0, `empty`=1, `count`=0; a subsequent pop sets `underflow`=1 and `restore` stays 0.
- Push 0x0010, 0x0020, 0x0030, then 3 pops → `RArestore`=0x0030, 0x0020, 0x0010 on consecutive cycles, `restore` high 3 cycles, `empty`=1 at end.
- DEPTH=8: push 0x0001..0x0009 (9 pushes) → `full`=1, `overflow`=1, `count`=8. Eight pops return 0x0009..0x0002, then `empty`=1.
- Push 0x1111, then push 0x2222 with pop in the same cycle → `RArestore`=0x1111 with `restore`; `count`=1; next pop returns 0x2222.
- Force `overflow` and `underflow`, assert `clear_err` → both clear next edge. `clear_err` together with a pop while empty → `underflow` stays 1.
- Push 0xBEEF then pop in the next cycle → `RArestore`=0xBEEF after the pop edge. `RArestore` then holds 0xBEEF for 5 idle cycles with `restore`=0.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared constants and types for the program counting system.
//   WIDTH          : PC/RA address width
//   RA_STACK_DEPTH : default number of return-address stack entries
//   ptr_w()        : pointer width for a power-of-two depth
//   ra_op_e        : decoded stack operation for one cycle
package pcs_pkg;

    localparam int unsigned WIDTH          = 16;
    localparam int unsigned RA_STACK_DEPTH = 8;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } ra_op_e;

endpackage

// File: rtl/ra_stack_if.sv
// Call/return interface between the control unit (master) and the
// return-address stack (slave).
//   push, pop, RA, clear_err : requests from the control unit
//   RArestore, restore       : popped value and its one-cycle valid pulse
//   count, full, empty       : occupancy status
//   overflow, underflow      : sticky error flags
interface ra_stack_if #(
    parameter int unsigned DEPTH = pcs_pkg::RA_STACK_DEPTH,
    parameter int unsigned WIDTH = pcs_pkg::WIDTH
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] RA;
    logic             clear_err;
    logic [WIDTH-1:0] RArestore;
    logic             restore;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, RA, clear_err,
        input  RArestore, restore, count, full, empty, overflow, underflow
    );

    modport slave (
        input  push, pop, RA, clear_err,
        output RArestore, restore, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/ra_stack_mem.sv
// DEPTH x WIDTH register file for the return-address stack.
//   clk   : write clock
//   we    : write enable, waddr/wdata : write port
//   raddr : asynchronous read address, rdata : read data
// Contents are deliberately not reset.
module ra_stack_mem #(
    parameter int unsigned DEPTH = pcs_pkg::RA_STACK_DEPTH,
    parameter int unsigned WIDTH = pcs_pkg::WIDTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/ra_stack.sv
// Circular return-address stack.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : call/return interface (slave side)
// A push when full overwrites the oldest entry; push+pop on a non-empty
// stack replaces the top after returning its old value.
module ra_stack
    import pcs_pkg::*;
#(
    parameter int unsigned DEPTH = pcs_pkg::RA_STACK_DEPTH,
    parameter int unsigned WIDTH = pcs_pkg::WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    ra_stack_if.slave  bus
);
    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    tp_q, tp_d, tp_m1;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rarestore_q, rarestore_d;
    logic             restore_q, restore_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             full, empty;
    logic             mem_we;
    logic [PW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_rdata;
    ra_op_e           op;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign tp_m1 = tp_q - PW'(1);

    // A pop on an empty stack is ignored, so push+pop then degrades to push.
    always_comb begin
        op = OP_IDLE;
        if (bus.pop && !empty) begin
            op = bus.push ? OP_REPLACE : OP_POP;
        end else if (bus.push) begin
            op = OP_PUSH;
        end
    end

    assign mem_we    = (op == OP_PUSH) || (op == OP_REPLACE);
    assign mem_waddr = (op == OP_REPLACE) ? tp_m1 : tp_q;

    ra_stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (bus.RA),
        .raddr (tp_m1),
        .rdata (mem_rdata)
    );

    always_comb begin
        tp_d        = tp_q;
        count_d     = count_q;
        rarestore_d = rarestore_q;
        restore_d   = 1'b0;
        case (op)
            OP_PUSH: begin
                tp_d = tp_q + PW'(1);
                if (!full) begin
                    count_d = count_q + CW'(1);
                end
            end
            OP_POP: begin
                tp_d        = tp_m1;
                count_d     = count_q - CW'(1);
                rarestore_d = mem_rdata;
                restore_d   = 1'b1;
            end
            OP_REPLACE: begin
                rarestore_d = mem_rdata;
                restore_d   = 1'b1;
            end
            default: ;
        endcase
        // A new error event wins over a coincident clear.
        overflow_d  = ((op == OP_PUSH) && full) || (overflow_q && !bus.clear_err);
        underflow_d = (bus.pop && empty) || (underflow_q && !bus.clear_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tp_q        <= '0;
            count_q     <= '0;
            rarestore_q <= '0;
            restore_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tp_q        <= tp_d;
            count_q     <= count_d;
            rarestore_q <= rarestore_d;
            restore_q   <= restore_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.RArestore = rarestore_q;
    assign bus.restore   = restore_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_ra_stack.sv
// Self-checking bench for ra_stack: directed vector table, a mid-operation
// reset sequence, then randomized traffic against a queue-based model.
module tb_ra_stack;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic reset;

    ra_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    ra_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic        p;
        logic        po;
        logic        ce;
        logic [15:0] ra;
        logic        er;
        logic [15:0] erar;
        int unsigned ecnt;
        logic        eo;
        logic        eu;
    } vec_t;

    vec_t vt[$];

    // reference model: queue with the newest entry at the back
    logic [15:0] mq[$];
    logic [15:0] m_rar;
    logic        m_rst;
    logic        m_ovf;
    logic        m_udf;

    function automatic void add(input logic p, input logic po, input logic ce,
                                input logic [15:0] ra, input logic er,
                                input logic [15:0] erar, input int unsigned ecnt,
                                input logic eo, input logic eu);
        vec_t v;
        v.p = p; v.po = po; v.ce = ce; v.ra = ra;
        v.er = er; v.erar = erar; v.ecnt = ecnt; v.eo = eo; v.eu = eu;
        vt.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic er, input logic [15:0] erar,
                             input int unsigned ecnt, input logic eo, input logic eu);
        chk({tag, ".restore"},   32'(bus.restore),   32'(er));
        chk({tag, ".RArestore"}, 32'(bus.RArestore), 32'(erar));
        chk({tag, ".count"},     32'(bus.count),     ecnt);
        chk({tag, ".full"},      32'(bus.full),      32'(ecnt == DEPTH));
        chk({tag, ".empty"},     32'(bus.empty),     32'(ecnt == 0));
        chk({tag, ".overflow"},  32'(bus.overflow),  32'(eo));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(eu));
    endtask

    task automatic drive(input logic p, input logic po, input logic [15:0] ra, input logic ce);
        @(negedge clk);
        bus.push      = p;
        bus.pop       = po;
        bus.RA        = ra;
        bus.clear_err = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic p, input logic po, input logic [15:0] ra, input logic ce);
        logic ovf_ev, udf_ev;
        ovf_ev = 1'b0;
        udf_ev = 1'b0;
        m_rst  = 1'b0;
        if (po && mq.size() > 0) begin
            m_rar = mq[$];
            m_rst = 1'b1;
            void'(mq.pop_back());
            if (p) mq.push_back(ra);
        end else begin
            if (po) udf_ev = 1'b1;
            if (p) begin
                if (mq.size() == DEPTH) begin
                    void'(mq.pop_front());
                    ovf_ev = 1'b1;
                end
                mq.push_back(ra);
            end
        end
        m_ovf = ovf_ev || (m_ovf && !ce);
        m_udf = udf_ev || (m_udf && !ce);
    endtask

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.RA = '0; bus.clear_err = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 16'h0000, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // directed table
        add(1,0,0,16'h0010, 0,16'h0000,1,0,0);
        add(1,0,0,16'h0020, 0,16'h0000,2,0,0);
        add(1,0,0,16'h0030, 0,16'h0000,3,0,0);
        add(0,1,0,16'h0000, 1,16'h0030,2,0,0);
        add(0,1,0,16'h0000, 1,16'h0020,1,0,0);
        add(0,1,0,16'h0000, 1,16'h0010,0,0,0);
        add(0,0,0,16'h0000, 0,16'h0010,0,0,0);
        add(0,1,0,16'h0000, 0,16'h0010,0,0,1);
        add(0,0,1,16'h0000, 0,16'h0010,0,0,0);
        for (int k = 1; k <= 8; k++) add(1,0,0,16'(k), 0,16'h0010,k,0,0);
        add(1,0,1,16'h0009, 0,16'h0010,8,1,0);   // overflow set beats clear
        for (int k = 0; k < 8; k++) add(0,1,0,16'h0000, 1,16'(9-k),7-k,1,0);
        add(0,0,0,16'h0000, 0,16'h0002,0,1,0);
        add(0,1,1,16'h0000, 0,16'h0002,0,0,1);   // underflow set beats clear
        add(0,0,1,16'h0000, 0,16'h0002,0,0,0);
        add(1,0,0,16'h1111, 0,16'h0002,1,0,0);
        add(1,1,0,16'h2222, 1,16'h1111,1,0,0);
        add(0,1,0,16'h0000, 1,16'h2222,0,0,0);
        add(1,1,0,16'h3333, 0,16'h2222,1,0,1);   // push+pop while empty
        add(0,0,1,16'h0000, 0,16'h2222,1,0,0);
        add(0,1,0,16'h0000, 1,16'h3333,0,0,0);
        add(1,0,0,16'hBEEF, 0,16'h3333,1,0,0);
        add(0,1,0,16'h0000, 1,16'hBEEF,0,0,0);
        for (int k = 0; k < 5; k++) add(0,0,0,16'h0000, 0,16'hBEEF,0,0,0);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].p, vt[i].po, vt[i].ra, vt[i].ce);
            check_all($sformatf("vec%0d", i), vt[i].er, vt[i].erar, vt[i].ecnt, vt[i].eo, vt[i].eu);
        end

        // reset while a pop result is being presented
        drive(1'b1, 1'b0, 16'h0AAA, 1'b0);
        drive(1'b1, 1'b0, 16'h0BBB, 1'b0);
        drive(1'b0, 1'b1, 16'h0000, 1'b0);
        check_all("midpop", 1'b1, 16'h0BBB, 1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_all("midrst", 1'b0, 16'h0000, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b1, 16'h0000, 1'b0);
        check_all("rstpop", 1'b0, 16'h0000, 0, 1'b0, 1'b1);

        // randomized traffic against the model, starting from the state above
        mq.delete();
        m_rar = 16'h0000; m_rst = 1'b0; m_ovf = 1'b0; m_udf = 1'b1;
        for (int i = 0; i < 600; i++) begin
            logic p, po, ce;
            logic [15:0] ra;
            if (i < 300) begin
                p  = ($urandom_range(0, 99) < 70);
                po = ($urandom_range(0, 99) < 35);
            end else begin
                p  = ($urandom_range(0, 99) < 35);
                po = ($urandom_range(0, 99) < 70);
            end
            ce = ($urandom_range(0, 99) < 6);
            ra = 16'($urandom);
            drive(p, po, ra, ce);
            model_step(p, po, ra, ce);
            check_all($sformatf("rnd%0d", i), m_rst, m_rar, mq.size(), m_ovf, m_udf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
